// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the ROM from fetch_pc, queues returned words
// with their addresses and presents the queue head to decode; redirect flushes.
module instr_fetch #(
  parameter int             IW       = 9,
  parameter int             AW       = 16,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          inst_valid,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          inflight;
  logic [IW-1:0] q_inst [DEPTH];
  logic [AW-1:0] q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;
  logic          push;
  logic          pop;

  // Credit counts the pre-pop occupancy plus the outstanding read, so a
  // response always has a free slot even if decode stalls meanwhile.
  assign credit     = count + CW'(inflight);
  assign imem_rd    = !reset && !redirect && (credit < CW'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign inst_valid = !reset && !redirect && (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Keep rd_ptr so the (now invalid) head outputs stay stable.
      wr_ptr   <= rd_ptr;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= redirect_pc;
    end else begin
      if (imem_rd) begin
        fetch_pc <= fetch_pc + AW'(1);
        req_pc   <= fetch_pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        q_inst[wr_ptr] <= imem_data;
        q_pc[wr_ptr]   <= req_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    push |-> (count < CW'(DEPTH)));

endmodule
